// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the byte-serial memory controller: widths, op codes,
// FSM state encodings and small byte/extension helpers.
package mem_ctrl_pkg;

  localparam int DAT_W = 32;
  localparam int OP_W  = 4;

  localparam logic [OP_W-1:0] LB  = 4'd0;
  localparam logic [OP_W-1:0] LH  = 4'd1;
  localparam logic [OP_W-1:0] LW  = 4'd2;
  localparam logic [OP_W-1:0] LBU = 4'd3;
  localparam logic [OP_W-1:0] LHU = 4'd4;
  localparam logic [OP_W-1:0] SB  = 4'd5;
  localparam logic [OP_W-1:0] SH  = 4'd6;
  localparam logic [OP_W-1:0] SW  = 4'd7;

  // Addresses with both of these bits set map to the UART.
  localparam logic [31:0] IO_MASK = 32'h0003_0000;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DLOAD  = 3'd1;
  localparam logic [2:0] ST_DSTORE = 3'd2;
  localparam logic [2:0] ST_FETCH  = 3'd3;
  localparam logic [2:0] ST_IOWAIT = 3'd4;

  function automatic logic is_io(input logic [31:0] adr);
    return (adr & IO_MASK) == IO_MASK;
  endfunction

  function automatic logic [7:0] byte_of(input logic [DAT_W-1:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [DAT_W-1:0] load_ext(input logic [OP_W-1:0] op, input logic [DAT_W-1:0] w);
    logic [DAT_W-1:0] r;
    case (op)
      LB:      r = {{24{w[7]}}, w[7:0]};
      LBU:     r = {24'b0, w[7:0]};
      LH:      r = {{16{w[15]}}, w[15:0]};
      LHU:     r = {16'b0, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates LSB data requests over instruction
// fetches and moves 1/2/4-byte transfers through a single byte-wide RAM port.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             br_flag_i,
  input  logic             lsb_en_i,
  input  logic             lsb_rwen_i,
  input  logic [OP_W-1:0]  lsb_op_i,
  input  logic [2:0]       lsb_len_i,
  input  logic [31:0]      lsb_adr_i,
  input  logic [DAT_W-1:0] lsb_dat_i,
  output logic             lsb_done_o,
  output logic [DAT_W-1:0] lsb_dat_o,
  input  logic             if_en_i,
  input  logic [31:0]      if_adr_i,
  output logic             if_done_o,
  output logic [DAT_W-1:0] if_dat_o,
  input  logic [7:0]       mem_din_i,
  output logic [7:0]       mem_dout_o,
  output logic [31:0]      mem_a_o,
  output logic             mem_wr_o,
  input  logic             io_buffer_full_i,
  output logic [2:0]       dbg_state_o
);

  // Handshakes: lsb_en_i is a one-cycle pulse (latched into the pending slot
  // when busy); if_en_i stays high until if_done_o; each done is a 1-cycle pulse.
  logic [2:0]       r_state;
  logic [2:0]       r_cnt;
  logic [7:0]       r_buf [0:3];
  logic [OP_W-1:0]  r_op;
  logic [2:0]       r_len;
  logic [31:0]      r_adr;
  logic [DAT_W-1:0] r_dat;

  logic             r_p_vld;
  logic             r_p_rwen;
  logic [OP_W-1:0]  r_p_op;
  logic [2:0]       r_p_len;
  logic [31:0]      r_p_adr;
  logic [DAT_W-1:0] r_p_dat;

  logic             w_req_rwen;
  logic [OP_W-1:0]  w_req_op;
  logic [2:0]       w_req_len;
  logic [31:0]      w_req_adr;
  logic [DAT_W-1:0] w_req_dat;
  logic             w_req_go;
  logic             w_take_data;
  logic             w_take_fetch;
  logic [2:0]       w_cnt_nx;
  logic             w_last;
  logic [DAT_W-1:0] w_word;

  assign w_req_rwen = r_p_vld ? r_p_rwen : lsb_rwen_i;
  assign w_req_op   = r_p_vld ? r_p_op   : lsb_op_i;
  assign w_req_len  = r_p_vld ? r_p_len  : lsb_len_i;
  assign w_req_adr  = r_p_vld ? r_p_adr  : lsb_adr_i;
  assign w_req_dat  = r_p_vld ? r_p_dat  : lsb_dat_i;

  // A flush kills outstanding loads but a store must always go out.
  assign w_req_go     = (r_p_vld | lsb_en_i) & (w_req_rwen | ~br_flag_i);
  assign w_take_data  = (r_state == ST_IDLE) & w_req_go;
  assign w_take_fetch = (r_state == ST_IDLE) & ~w_req_go & if_en_i & ~br_flag_i;

  assign w_cnt_nx    = r_cnt + 3'd1;
  assign w_last      = (w_cnt_nx == r_len);
  assign dbg_state_o = r_state;

  // The final byte bypasses the buffer so the result is ready at edge N.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < 4; i++) begin
      w_word[8*i +: 8] = (r_cnt[1:0] == 2'(i)) ? mem_din_i : r_buf[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_len      <= '0;
      r_adr      <= '0;
      r_dat      <= '0;
      for (int i = 0; i < 4; i++) r_buf[i] <= '0;
      r_p_vld    <= 1'b0;
      r_p_rwen   <= 1'b0;
      r_p_op     <= '0;
      r_p_len    <= '0;
      r_p_adr    <= '0;
      r_p_dat    <= '0;
      lsb_done_o <= 1'b0;
      lsb_dat_o  <= '0;
      if_done_o  <= 1'b0;
      if_dat_o   <= '0;
      mem_dout_o <= '0;
      mem_a_o    <= '0;
      mem_wr_o   <= 1'b0;
    end else if (en) begin
      lsb_done_o <= 1'b0;
      if_done_o  <= 1'b0;

      if (w_take_data) begin
        r_p_vld <= 1'b0;
      end else if (lsb_en_i && r_state != ST_IDLE && (lsb_rwen_i || !br_flag_i)) begin
        r_p_vld  <= 1'b1;
        r_p_rwen <= lsb_rwen_i;
        r_p_op   <= lsb_op_i;
        r_p_len  <= lsb_len_i;
        r_p_adr  <= lsb_adr_i;
        r_p_dat  <= lsb_dat_i;
      end else if (br_flag_i && !r_p_rwen) begin
        r_p_vld <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_take_data) begin
            r_op    <= w_req_op;
            r_len   <= w_req_len;
            r_adr   <= w_req_adr;
            r_dat   <= w_req_dat;
            r_cnt   <= '0;
            mem_a_o <= w_req_adr;
            if (!w_req_rwen) begin
              r_state <= ST_DLOAD;
            end else if (is_io(w_req_adr) && io_buffer_full_i) begin
              r_state <= ST_IOWAIT;
            end else begin
              r_state    <= ST_DSTORE;
              mem_wr_o   <= 1'b1;
              mem_dout_o <= w_req_dat[7:0];
            end
          end else if (w_take_fetch) begin
            r_op    <= LW;
            r_len   <= 3'd4;
            r_adr   <= if_adr_i;
            r_cnt   <= '0;
            mem_a_o <= if_adr_i;
            r_state <= ST_FETCH;
          end
        end
        ST_DLOAD, ST_FETCH: begin
          if (br_flag_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_buf[r_cnt[1:0]] <= mem_din_i;
            if (w_last) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
              if (r_state == ST_DLOAD) begin
                lsb_done_o <= 1'b1;
                lsb_dat_o  <= load_ext(r_op, w_word);
              end else begin
                if_done_o <= 1'b1;
                if_dat_o  <= w_word;
              end
            end else begin
              r_cnt   <= w_cnt_nx;
              mem_a_o <= r_adr + 32'(w_cnt_nx);
            end
          end
        end
        ST_DSTORE: begin
          if (w_last) begin
            mem_wr_o   <= 1'b0;
            lsb_done_o <= 1'b1;
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
          end else begin
            r_cnt      <= w_cnt_nx;
            mem_a_o    <= r_adr + 32'(w_cnt_nx);
            mem_dout_o <= byte_of(r_dat, w_cnt_nx[1:0]);
          end
        end
        ST_IOWAIT: begin
          if (!io_buffer_full_i) begin
            r_state    <= ST_DSTORE;
            mem_wr_o   <= 1'b1;
            mem_dout_o <= r_dat[7:0];
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed scenarios plus randomized loads/stores checked
// against a byte-array memory model and an expected-write queue.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, br_flag, lsb_en, lsb_rwen, if_en, io_full;
  logic [3:0]  lsb_op;
  logic [2:0]  lsb_len;
  logic [31:0] lsb_adr, lsb_dat_in, if_adr;
  logic        lsb_done, if_done, mem_wr;
  logic [31:0] lsb_dat, if_dat, mem_a;
  logic [7:0]  mem_din, mem_dout;
  logic [2:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0]  ram [0:4095];
  logic [7:0]  mdl [0:4095];
  logic [39:0] wr_q [$];
  int          wr_cyc_q [$];
  logic [39:0] exp_q [$];

  // ---------------- clock / reset / memory ----------------
  always #5 clk = ~clk;

  always_comb mem_din = ram[mem_a[11:0]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) ram[i] <= mdl[i];
    end else if (mem_wr) begin
      ram[mem_a[11:0]] <= mem_dout;
      wr_q.push_back({mem_a, mem_dout});
      wr_cyc_q.push_back(cyc);
    end
    cyc <= cyc + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  mem_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .br_flag_i(br_flag),
    .lsb_en_i(lsb_en), .lsb_rwen_i(lsb_rwen), .lsb_op_i(lsb_op),
    .lsb_len_i(lsb_len), .lsb_adr_i(lsb_adr), .lsb_dat_i(lsb_dat_in),
    .lsb_done_o(lsb_done), .lsb_dat_o(lsb_dat),
    .if_en_i(if_en), .if_adr_i(if_adr), .if_done_o(if_done), .if_dat_o(if_dat),
    .mem_din_i(mem_din), .mem_dout_o(mem_dout), .mem_a_o(mem_a), .mem_wr_o(mem_wr),
    .io_buffer_full_i(io_full), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdl_load(input logic [3:0] op, input int len, input logic [31:0] adr);
    longint v = 0;
    for (int k = 0; k < len; k++) v += longint'(mdl[12'(adr + 32'(k))]) << (8 * k);
    if ((op == LB || op == LH) && v >= (longint'(1) << (8 * len - 1)))
      v -= longint'(1) << (8 * len);
    return 32'(v);
  endfunction

  task automatic expect_store(input int len, input logic [31:0] adr, input logic [31:0] dat);
    for (int k = 0; k < len; k++) begin
      logic [7:0] b;
      b = 8'(dat >> (8 * k));
      exp_q.push_back({adr + 32'(k), b});
      mdl[12'(adr + 32'(k))] = b;
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwrites"}, 64'(wr_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && wr_q.size() > 0)
      check({tag, "_wbyte"}, 64'(wr_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lsb_req(input logic rw, input logic [3:0] op, input int len,
                         input logic [31:0] adr, input logic [31:0] dat);
    lsb_en = 1'b1; lsb_rwen = rw; lsb_op = op; lsb_len = 3'(len);
    lsb_adr = adr; lsb_dat_in = dat;
    tick();
    lsb_en = 1'b0;
  endtask

  task automatic wait_lsb(input int bound, output int n, output logic ok);
    n = 0; ok = 1'b0;
    while (n < bound && !ok) begin
      if (lsb_done) ok = 1'b1;
      else begin tick(); n++; end
    end
  endtask

  task automatic wait_if(input int bound, output int n, output logic ok);
    n = 0; ok = 1'b0;
    while (n < bound && !ok) begin
      if (if_done) ok = 1'b1;
      else begin tick(); n++; end
    end
  endtask

  task automatic run_load(input string tag, input logic [3:0] op, input int len, input logic [31:0] adr);
    logic [31:0] exp;
    int n;
    logic ok;
    exp = mdl_load(op, len, adr);
    lsb_req(1'b0, op, len, adr, 32'h0);
    wait_lsb(20, n, ok);
    check({tag, "_done"}, 64'(ok), 64'(1));
    check({tag, "_latency"}, 64'(n), 64'(len));
    check({tag, "_data"}, 64'(lsb_dat), 64'(exp));
    tick();
    check({tag, "_pulse"}, 64'(lsb_done), 64'(0));
  endtask

  task automatic run_store(input string tag, input logic [3:0] op, input int len,
                           input logic [31:0] adr, input logic [31:0] dat, input int br_at);
    int n, n_pre;
    logic ok;
    wr_q.delete(); wr_cyc_q.delete(); exp_q.delete();
    expect_store(len, adr, dat);
    lsb_req(1'b1, op, len, adr, dat);
    n_pre = 0;
    if (br_at > 0) begin
      repeat (br_at - 1) tick();
      br_flag = 1'b1;
      tick();
      br_flag = 1'b0;
      n_pre = br_at;
    end
    wait_lsb(20, n, ok);
    check({tag, "_done"}, 64'(ok), 64'(1));
    check({tag, "_latency"}, 64'(n + n_pre), 64'(len));
    check({tag, "_wr_low"}, 64'(mem_wr), 64'(0));
    check_writes(tag);
    tick();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n, x;
    logic ok, seen;
    logic [31:0] exp;

    rst = 1'b1; en = 1'b1; br_flag = 1'b0; lsb_en = 1'b0; lsb_rwen = 1'b0;
    lsb_op = '0; lsb_len = '0; lsb_adr = '0; lsb_dat_in = '0;
    if_en = 1'b0; if_adr = '0; io_full = 1'b0;
    for (int i = 0; i < 4096; i++) mdl[i] = 8'($urandom_range(0, 255));
    mdl[12'h100] = 8'h78; mdl[12'h101] = 8'h56; mdl[12'h102] = 8'h34; mdl[12'h103] = 8'h12;
    mdl[12'h180] = 8'h80;
    repeat (3) tick();
    check("rst_lsb_done", 64'(lsb_done), 64'(0));
    check("rst_if_done", 64'(if_done), 64'(0));
    check("rst_lsb_dat", 64'(lsb_dat), 64'(0));
    check("rst_if_dat", 64'(if_dat), 64'(0));
    check("rst_mem_port", 64'({mem_wr, mem_a, mem_dout}), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0;
    tick();

    // LW of a known word, then sign/zero-extended byte loads
    lsb_req(1'b0, LW, 4, 32'h100, 32'h0);
    wait_lsb(20, n, ok);
    check("lw_done", 64'(ok), 64'(1));
    check("lw_latency", 64'(n), 64'(4));
    check("lw_data", 64'(lsb_dat), 64'h1234_5678);
    tick();
    check("lw_pulse", 64'(lsb_done), 64'(0));
    lsb_req(1'b0, LB, 1, 32'h180, 32'h0);
    wait_lsb(20, n, ok);
    check("lb_data", 64'(lsb_dat), 64'hFFFF_FF80);
    tick();
    lsb_req(1'b0, LBU, 1, 32'h180, 32'h0);
    wait_lsb(20, n, ok);
    check("lbu_data", 64'(lsb_dat), 64'h0000_0080);
    tick();

    // SH: two consecutive write cycles, low byte first
    run_store("sh", SH, 2, 32'h200, 32'h0000_BEEF, 0);
    check("sh_consecutive", 64'(wr_cyc_q.size() == 2 ? wr_cyc_q[1] - wr_cyc_q[0] : 0), 64'(1));
    run_load("sh_readback", LHU, 2, 32'h200);

    // randomized mix of loads and stores
    for (int i = 0; i < 24; i++) begin
      int len, sel;
      logic [31:0] adr;
      logic [3:0] op;
      sel = $urandom_range(0, 2);
      len = (sel == 0) ? 1 : (sel == 1) ? 2 : 4;
      adr = 32'($urandom_range(0, 4000));
      if ($urandom_range(0, 1) == 1) begin
        op = (len == 1) ? SB : (len == 2) ? SH : SW;
        run_store("rnd_st", op, len, adr, $urandom, 0);
      end else begin
        if (len == 4) op = LW;
        else if (len == 2) op = ($urandom_range(0, 1) == 1) ? LH : LHU;
        else op = ($urandom_range(0, 1) == 1) ? LB : LBU;
        run_load("rnd_ld", op, len, adr);
      end
    end

    // fetch in progress, load pulse arrives: fetch first, load right after
    if_adr = 32'h300; if_en = 1'b1;
    tick(); tick();
    lsb_req(1'b0, LW, 4, 32'h340, 32'h0);
    wait_if(20, n, ok);
    check("fq_if_done", 64'(ok), 64'(1));
    check("fq_if_dat", 64'(if_dat), 64'(mdl_load(LW, 4, 32'h300)));
    check("fq_lsb_not_yet", 64'(lsb_done), 64'(0));
    if_en = 1'b0;
    wait_lsb(20, n, ok);
    check("fq_lsb_done", 64'(ok), 64'(1));
    check("fq_lsb_gap", 64'(n), 64'(5));
    check("fq_lsb_dat", 64'(lsb_dat), 64'(mdl_load(LW, 4, 32'h340)));
    tick();

    // data request and fetch together: data wins
    if_adr = 32'h404; if_en = 1'b1;
    exp = mdl_load(LH, 2, 32'h7A1);
    lsb_req(1'b0, LH, 2, 32'h7A1, 32'h0);
    wait_lsb(20, n, ok);
    check("sim_lsb_first", 64'({ok, if_done}), 64'(2'b10));
    check("sim_lsb_dat", 64'(lsb_dat), 64'(exp));
    wait_if(20, n, ok);
    check("sim_if_dat", 64'({ok, if_dat}), 64'({1'b1, mdl_load(LW, 4, 32'h404)}));
    if_en = 1'b0;
    tick();

    // flush two cycles into a LW: no done, back to idle
    lsb_req(1'b0, LW, 4, 32'h100, 32'h0);
    tick();
    br_flag = 1'b1; tick(); br_flag = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin seen |= lsb_done; tick(); end
    check("br_lw_nodone", 64'(seen), 64'(0));
    check("br_lw_idle", 64'(dbg_state), 64'(ST_IDLE));

    // flush coinciding with the final load edge
    lsb_req(1'b0, LW, 4, 32'h100, 32'h0);
    repeat (3) tick();
    br_flag = 1'b1; tick(); br_flag = 1'b0;
    seen = lsb_done;
    for (int i = 0; i < 4; i++) begin tick(); seen |= lsb_done; end
    check("br_last_nodone", 64'(seen), 64'(0));
    check("br_last_idle", 64'(dbg_state), 64'(ST_IDLE));

    // flush mid-SW: store still completes
    run_store("br_sw", SW, 4, 32'h500, 32'hCAFE_F00D, 2);

    // IO store held off by a full UART buffer
    io_full = 1'b1;
    wr_q.delete(); wr_cyc_q.delete(); exp_q.delete();
    expect_store(1, 32'h0003_0000, 32'h0000_00A5);
    lsb_req(1'b1, SB, 1, 32'h0003_0000, 32'h0000_00A5);
    repeat (4) tick();
    check("io_no_write", 64'(wr_q.size()), 64'(0));
    check("io_wait_state", 64'(dbg_state), 64'(ST_IOWAIT));
    x = cyc;
    io_full = 1'b0;
    wait_lsb(20, n, ok);
    check("io_done", 64'({ok, 8'(n)}), 64'({1'b1, 8'd2}));
    check("io_write_cycle", 64'(wr_cyc_q.size() > 0 ? wr_cyc_q[0] : -1), 64'(x + 1));
    check_writes("io");
    tick();

    // en low stretches a load and freezes the done pulse
    exp = mdl_load(LHU, 2, 32'h9F3);
    lsb_req(1'b0, LHU, 2, 32'h9F3, 32'h0);
    en = 1'b0;
    repeat (3) tick();
    en = 1'b1;
    wait_lsb(20, n, ok);
    check("en_latency", 64'({ok, 8'(n)}), 64'({1'b1, 8'd2}));
    check("en_data", 64'(lsb_dat), 64'(exp));
    en = 1'b0;
    tick();
    check("en_hold_done", 64'({lsb_done, lsb_dat}), 64'({1'b1, exp}));
    en = 1'b1;
    tick();
    check("en_release", 64'(lsb_done), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
